dmem_access_ctrl: RTL and testbench



---
 rtl/dmem_access_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: arbitrates core, debug/DMA and ALU write-back,
// and generates address, pointer-drive and read/write strobes for the array.
module dmem_access_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int PTR_BASE = 26
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [1:0]            req,
    input  logic [1:0]            req_we,
    input  logic [1:0]            req_ind,
    input  logic [3:0]            req_ptr,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            ack,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            err,
    input  logic                  alu_wr_req,
    output logic                  alu_ack,
    inout  wire  [DATA_W-1:0]     databus,
    output logic [ADDR_W-1:0]     addbus,
    output logic [5:0]            point_add,
    output logic                  rd,
    output logic                  rd_latch,
    output logic                  wr,
    output logic                  alu_write,
    output logic                  busy
);

    // The six pointer cells must sit inside the addressable range.
    if (PTR_BASE < 0 || PTR_BASE + 6 > (1 << ADDR_W)) begin : g_ptr_range
        $error("pointer pair region outside address space");
    end

    typedef enum logic [2:0] {
        IDLE, SETUP, RD, LATCH, WR, HOLD, ALUW, DONE
    } state_t;

    state_t state, next;

    logic              gnt;
    logic              prio;
    logic              we_q;
    logic              ind_q;
    logic [1:0]        ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              alu_q;
    logic              err_q;

    logic              sel;
    logic              sel_ind;
    logic [1:0]        sel_ptr;
    logic              sel_bad;
    logic              in_access;
    logic              addr_drv;
    logic              data_drv;

    // Last-granted requester loses a tie; a lone request always wins.
    always_comb begin
        sel = req[1];
        if (req == 2'b11)
            sel = prio;
    end

    assign sel_ind = sel ? req_ind[1] : req_ind[0];
    assign sel_ptr = sel ? req_ptr[3:2] : req_ptr[1:0];
    assign sel_bad = sel_ind && (sel_ptr == 2'd3);

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (alu_wr_req)
                    next = ALUW;
                else if (|req)
                    next = sel_bad ? DONE : SETUP;
            end
            SETUP:   next = we_q ? WR : RD;
            RD:      next = LATCH;
            LATCH:   next = DONE;
            WR:      next = HOLD;
            HOLD:    next = DONE;
            ALUW:    next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            state <= IDLE;
        else
            state <= next;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            gnt     <= 1'b0;
            prio    <= 1'b0;
            we_q    <= 1'b0;
            ind_q   <= 1'b0;
            ptr_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            alu_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (state == IDLE) begin
            if (alu_wr_req) begin
                alu_q <= 1'b1;
                err_q <= 1'b0;
                we_q  <= 1'b0;
                ind_q <= 1'b0;
            end else if (|req) begin
                gnt     <= sel;
                prio    <= ~sel;
                alu_q   <= 1'b0;
                err_q   <= sel_bad;
                we_q    <= sel ? req_we[1] : req_we[0];
                ind_q   <= sel_ind;
                ptr_q   <= sel_ptr;
                addr_q  <= sel ? req_addr[2*ADDR_W-1:ADDR_W]
                               : req_addr[ADDR_W-1:0];
                wdata_q <= sel ? req_wdata[2*DATA_W-1:DATA_W]
                               : req_wdata[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            rdata <= '0;
        else if (state == LATCH)
            rdata <= databus;
    end

    assign in_access = (state == SETUP) || (state == RD) ||
                       (state == LATCH) || (state == WR) ||
                       (state == HOLD);

    // Write data only in write states, so never alongside rd.
    assign addr_drv = in_access && !ind_q;
    assign data_drv = we_q && ((state == SETUP) || (state == WR) ||
                               (state == HOLD));

    assign addbus    = addr_drv ? addr_q : {ADDR_W{1'bz}};
    assign databus   = data_drv ? wdata_q : {DATA_W{1'bz}};
    assign point_add = (in_access && ind_q) ?
                       (6'b000011 << {ptr_q, 1'b0}) : 6'b000000;

    assign rd        = (state == RD) || (state == LATCH);
    assign rd_latch  = (state == LATCH);
    assign wr        = (state == WR);
    assign alu_write = (state == ALUW);
    assign busy      = (state != IDLE);

    always_comb begin
        ack     = 2'b00;
        err     = 2'b00;
        alu_ack = 1'b0;
        if (state == DONE) begin
            if (alu_q) begin
                alu_ack = 1'b1;
            end else begin
                ack = gnt ? 2'b10 : 2'b01;
                err = err_q ? ack : 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a behavioural data memory
// that resolves direct and pointer-pair addresses.
module tb_dmem_access_ctrl;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int PTR_BASE = 26;

    logic                clk = 1'b0;
    logic                clr = 1'b0;
    logic [1:0]          req = '0;
    logic [1:0]          req_we = '0;
    logic [1:0]          req_ind = '0;
    logic [3:0]          req_ptr = '0;
    logic [2*ADDR_W-1:0] req_addr = '0;
    logic [2*DATA_W-1:0] req_wdata = '0;
    logic                alu_wr_req = 1'b0;

    wire [1:0]        ack;
    wire [1:0]        err;
    wire [DATA_W-1:0] rdata;
    wire              alu_ack;
    wire [DATA_W-1:0] databus;
    wire [ADDR_W-1:0] addbus;
    wire [5:0]        point_add;
    wire              rd, rd_latch, wr, alu_write, busy;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PTR_BASE(PTR_BASE)
    ) dut (
        .clk(clk), .clr(clr), .req(req), .req_we(req_we),
        .req_ind(req_ind), .req_ptr(req_ptr), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .err(err),
        .alu_wr_req(alu_wr_req), .alu_ack(alu_ack), .databus(databus),
        .addbus(addbus), .point_add(point_add), .rd(rd),
        .rd_latch(rd_latch), .wr(wr), .alu_write(alu_write), .busy(busy)
    );

    // Behavioural memory
    logic [7:0]  mem [0:511];
    logic [15:0] eaddr;
    logic        pl_we = 1'b0;
    logic [8:0]  pl_addr = '0;
    logic [7:0]  pl_data = '0;

    always_comb begin
        int k;
        int e;
        k = -1;
        eaddr = addbus;
        for (int i = 5; i >= 0; i--)
            if (point_add[i]) k = i;
        if (k >= 0) begin
            e = PTR_BASE + (k & ~1);
            eaddr = {mem[e+1], mem[e]};
        end
    end

    assign databus = (rd && !wr) ? mem[eaddr[8:0]] : 8'bz;

    always @(posedge clk) begin
        if (pl_we)
            mem[pl_addr] <= pl_data;
        else if (wr)
            mem[eaddr[8:0]] <= databus;
    end

    typedef struct {
        logic [1:0] who;
        logic       alu;
        logic [7:0] data;
        logic       e;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic nxt_rr = 1'b0;

    task automatic preload(input int a, input logic [7:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a[8:0]; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic set_req(input int r, input logic we, input logic ind,
                           input logic [1:0] ptr, input logic [15:0] a,
                           input logic [7:0] d);
        req_we[r]             = we;
        req_ind[r]            = ind;
        req_ptr[2*r +: 2]     = ptr;
        req_addr[16*r +: 16]  = a;
        req_wdata[8*r +: 8]   = d;
        req[r]                = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            vectors++; miscompares++;
            $display("FAIL idle_timeout busy=%b want 0", busy);
        end
    endtask

    task automatic wait_done(output logic [1:0] a, output logic al,
                             output logic [1:0] e, output logic ok);
        ok = 1'b0; a = '0; al = 1'b0; e = '0;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            if (ack != 2'b00 || alu_ack) begin
                ok = 1'b1; a = ack; al = alu_ack; e = err;
            end
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL ack_timeout no ack within 30 cycles");
        end
    endtask

    task automatic test_reset();
        clr = 1'b0;
        #2;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy got %b want 0", busy);
        end
        vectors++;
        if ({ack, err, alu_ack, rd, rd_latch, wr, alu_write} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_strobes got %b want 0",
                     {ack, err, alu_ack, rd, rd_latch, wr, alu_write});
        end
        vectors++;
        if (rdata !== 8'h00 || point_add !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_regs rdata=%h pa=%b want 00/000000",
                     rdata, point_add);
        end
        vectors++;
        if (!(addbus === 16'h0 || addbus === 16'hzzzz)) begin
            miscompares++; $display("FAIL reset_addbus got %h want z", addbus);
        end
        @(negedge clk);
        clr = 1'b1;
        nxt_rr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_direct_read();
        exp_t x;
        wait_idle();
        sb.push_back('{who: 2'b01, alu: 1'b0, data: 8'hA7, e: 1'b0});
        set_req(0, 1'b0, 1'b0, 2'd0, 16'h0005, 8'h00);
        @(negedge clk);
        vectors++;
        if (addbus !== 16'h0005 || rd !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_setup addbus=%h rd=%b want 0005/0", addbus, rd);
        end
        @(negedge clk);
        vectors++;
        if (rd !== 1'b1 || rd_latch !== 1'b0 || wr !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_c2 rd=%b latch=%b wr=%b want 1/0/0",
                     rd, rd_latch, wr);
        end
        @(negedge clk);
        vectors++;
        if (rd !== 1'b1 || rd_latch !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_c3 rd=%b latch=%b want 1/1", rd, rd_latch);
        end
        @(negedge clk);
        x = sb.pop_front();
        vectors++;
        if (ack !== x.who || rdata !== x.data || err !== 2'b00) begin
            miscompares++;
            $display("FAIL rd_ack ack=%b rdata=%h err=%b want %b/%h/00",
                     ack, rdata, err, x.who, x.data);
        end
        req = 2'b00;
        nxt_rr = 1'b1;
    endtask

    task automatic test_direct_write();
        exp_t x;
        logic [1:0] a, e;
        logic al, ok;
        wait_idle();
        set_req(1, 1'b1, 1'b0, 2'd0, 16'h0100, 8'h3C);
        @(negedge clk);
        vectors++;
        if (databus !== 8'h3C || wr !== 1'b0 || addbus !== 16'h0100) begin
            miscompares++;
            $display("FAIL wr_setup db=%h wr=%b ab=%h want 3c/0/0100",
                     databus, wr, addbus);
        end
        @(negedge clk);
        vectors++;
        if (wr !== 1'b1 || databus !== 8'h3C || rd !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_pulse wr=%b db=%h rd=%b want 1/3c/0",
                     wr, databus, rd);
        end
        @(negedge clk);
        vectors++;
        if (wr !== 1'b0 || databus !== 8'h3C || addbus !== 16'h0100) begin
            miscompares++;
            $display("FAIL wr_hold wr=%b db=%h ab=%h want 0/3c/0100",
                     wr, databus, addbus);
        end
        @(negedge clk);
        vectors++;
        if (ack !== 2'b10) begin
            miscompares++; $display("FAIL wr_ack got %b want 10", ack);
        end
        req = 2'b00;
        nxt_rr = 1'b0;
        wait_idle();
        sb.push_back('{who: 2'b01, alu: 1'b0, data: 8'h3C, e: 1'b0});
        set_req(0, 1'b0, 1'b0, 2'd0, 16'h0100, 8'h00);
        wait_done(a, al, e, ok);
        req = 2'b00;
        x = sb.pop_front();
        if (ok) begin
            vectors++;
            if (a !== x.who || rdata !== x.data) begin
                miscompares++;
                $display("FAIL wr_readback ack=%b rdata=%h want %b/%h",
                         a, rdata, x.who, x.data);
            end
        end
        nxt_rr = 1'b1;
    endtask

    task automatic test_indirect_read();
        exp_t x;
        logic [1:0] a, e;
        logic al, ok;
        preload(28, 8'h20);
        preload(29, 8'h00);
        preload(32, 8'h55);
        wait_idle();
        sb.push_back('{who: 2'b01, alu: 1'b0, data: 8'h55, e: 1'b0});
        set_req(0, 1'b0, 1'b1, 2'd1, 16'h0005, 8'h00);
        @(negedge clk);
        vectors++;
        if (point_add !== 6'b001100 ||
            !(addbus === 16'h0 || addbus === 16'hzzzz)) begin
            miscompares++;
            $display("FAIL ind_setup pa=%b ab=%h want 001100/z",
                     point_add, addbus);
        end
        @(negedge clk);
        vectors++;
        if (point_add !== 6'b001100 || rd !== 1'b1) begin
            miscompares++;
            $display("FAIL ind_rd pa=%b rd=%b want 001100/1", point_add, rd);
        end
        wait_done(a, al, e, ok);
        req = 2'b00;
        x = sb.pop_front();
        if (ok) begin
            vectors++;
            if (a !== x.who || rdata !== x.data || point_add !== 6'd0) begin
                miscompares++;
                $display("FAIL ind_ack ack=%b rdata=%h pa=%b want %b/%h/0",
                         a, rdata, point_add, x.who, x.data);
            end
        end
        nxt_rr = 1'b1;
    endtask

    task automatic test_illegal_ptr();
        wait_idle();
        set_req(1, 1'b0, 1'b1, 2'd3, 16'h0005, 8'h00);
        @(negedge clk);
        vectors++;
        if (ack !== 2'b10 || err !== 2'b10) begin
            miscompares++;
            $display("FAIL ill_ack ack=%b err=%b want 10/10", ack, err);
        end
        vectors++;
        if (rd !== 1'b0 || wr !== 1'b0 || point_add !== 6'd0) begin
            miscompares++;
            $display("FAIL ill_quiet rd=%b wr=%b pa=%b want 0/0/0",
                     rd, wr, point_add);
        end
        req = 2'b00;
        @(negedge clk);
        vectors++;
        if (err !== 2'b00 || ack !== 2'b00) begin
            miscompares++;
            $display("FAIL ill_pulse err=%b ack=%b want 00/00", err, ack);
        end
        nxt_rr = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t x;
        logic [1:0] a, e;
        logic al, ok;
        logic g;
        wait_idle();
        g = nxt_rr;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{who: g ? 2'b10 : 2'b01, alu: 1'b0,
                           data: g ? 8'h3C : 8'hA7, e: 1'b0});
            g = ~g;
        end
        set_req(0, 1'b0, 1'b0, 2'd0, 16'h0005, 8'h00);
        set_req(1, 1'b0, 1'b0, 2'd0, 16'h0100, 8'h00);
        for (int i = 0; i < 4; i++) begin
            wait_done(a, al, e, ok);
            if (i == 3) req = 2'b00;
            x = sb.pop_front();
            if (ok) begin
                vectors++;
                if (a !== x.who || rdata !== x.data) begin
                    miscompares++;
                    $display("FAIL rr_grant%0d ack=%b rdata=%h want %b/%h",
                             i, a, rdata, x.who, x.data);
                end
            end
        end
        req = 2'b00;
        nxt_rr = g;
    endtask

    task automatic test_alu_priority();
        exp_t x;
        logic [1:0] a, e;
        logic al, ok;
        logic seen_aw;
        wait_idle();
        sb.push_back('{who: 2'b01, alu: 1'b0, data: 8'hA7, e: 1'b0});
        sb.push_back('{who: 2'b00, alu: 1'b1, data: 8'hA7, e: 1'b0});
        sb.push_back('{who: 2'b10, alu: 1'b0, data: 8'h3C, e: 1'b0});
        req_wdata = '0;
        set_req(0, 1'b0, 1'b0, 2'd0, 16'h0005, 8'h00);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 2'd0, 16'h0100, 8'h00);
        alu_wr_req = 1'b1;
        seen_aw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ok = 1'b0; a = '0; al = 1'b0;
            for (int n = 0; n < 30 && !ok; n++) begin
                @(negedge clk);
                if (alu_write) seen_aw = 1'b1;
                if (ack != 2'b00 || alu_ack) begin
                    ok = 1'b1; a = ack; al = alu_ack;
                end
            end
            if (al) alu_wr_req = 1'b0;
            if (a[0]) req[0] = 1'b0;
            if (a[1]) req[1] = 1'b0;
            x = sb.pop_front();
            vectors++;
            if (!ok || a !== x.who || al !== x.alu ||
                (!x.alu && rdata !== x.data)) begin
                miscompares++;
                $display("FAIL alu_order%0d ack=%b alu_ack=%b rdata=%h want %b/%b/%h",
                         i, a, al, rdata, x.who, x.alu, x.data);
            end
        end
        vectors++;
        if (!seen_aw) begin
            miscompares++; $display("FAIL alu_write got 0 want 1 pulse");
        end
        req = 2'b00;
        alu_wr_req = 1'b0;
        nxt_rr = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        exp_t x;
        logic [1:0] a, e;
        logic al, ok;
        wait_idle();
        set_req(1, 1'b1, 1'b0, 2'd0, 16'h0040, 8'h99);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (wr !== 1'b1) begin
            miscompares++; $display("FAIL rst_pre_wr got %b want 1", wr);
        end
        clr = 1'b0;
        #1;
        vectors++;
        if (wr !== 1'b0 || busy !== 1'b0 ||
            !(databus === 8'h0 || databus === 8'hzz) ||
            !(addbus === 16'h0 || addbus === 16'hzzzz)) begin
            miscompares++;
            $display("FAIL rst_release wr=%b busy=%b db=%h ab=%h want 0/0/z/z",
                     wr, busy, databus, addbus);
        end
        req = 2'b00;
        @(negedge clk);
        clr = 1'b1;
        nxt_rr = 1'b0;
        @(negedge clk);
        sb.push_back('{who: 2'b01, alu: 1'b0, data: 8'hA7, e: 1'b0});
        set_req(0, 1'b0, 1'b0, 2'd0, 16'h0005, 8'h00);
        wait_done(a, al, e, ok);
        req = 2'b00;
        x = sb.pop_front();
        if (ok) begin
            vectors++;
            if (a !== x.who || rdata !== x.data) begin
                miscompares++;
                $display("FAIL rst_after ack=%b rdata=%h want %b/%h",
                         a, rdata, x.who, x.data);
            end
        end
        nxt_rr = 1'b1;
    endtask

    initial begin
        test_reset();
        preload(5, 8'hA7);
        test_direct_read();
        test_direct_write();
        test_indirect_read();
        test_illegal_ptr();
        test_back_to_back();
        test_alu_priority();
        test_reset_mid_write();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
